// File: rtl/muldiv_hilo_pkg.sv
// muldiv_hilo_pkg: ALU op codes shared with the decoder, mul/div FSM states, magnitude helper
package muldiv_hilo_pkg;
   localparam logic [5:0] ALU_MFHI  = 6'h10;
   localparam logic [5:0] ALU_MTHI  = 6'h11;
   localparam logic [5:0] ALU_MFLO  = 6'h12;
   localparam logic [5:0] ALU_MTLO  = 6'h13;
   localparam logic [5:0] ALU_MULT  = 6'h18;
   localparam logic [5:0] ALU_MULTU = 6'h19;
   localparam logic [5:0] ALU_DIV   = 6'h1A;
   localparam logic [5:0] ALU_DIVU  = 6'h1B;
   typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t;
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction
endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// muldiv_hilo_div_iter: 32-cycle unsigned restoring divider, one quotient bit per cycle
//   clk, rst           clock, synchronous active-high reset
//   start, abort       load operands and begin / drop the in-flight divide
//   dividend, divisor  unsigned operands sampled on start
//   busy               iterations outstanding
//   quotient, remainder results, final once busy falls
module muldiv_hilo_div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);
   logic [4:0]  cnt;
   logic [31:0] dvsr;
   logic [32:0] shifted, diff;
   // quotient doubles as the dividend shift register; its top bit feeds the remainder
   always_comb begin
      shifted = {remainder, quotient[31]};
      diff    = shifted - {1'b0, dvsr};
   end
   always_ff @(posedge clk)
      if (rst) begin
         busy      <= 1'b0;
         cnt       <= '0;
         dvsr      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         cnt       <= '0;
         dvsr      <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (busy) begin
         remainder <= diff[32] ? shifted[31:0] : diff[31:0];
         quotient  <= {quotient[30:0], ~diff[32]};
         cnt       <= cnt + 5'd1;
         busy      <= cnt != 5'd31;
      end
endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: background multiply/divide unit owning the HI/LO registers
//   clk, rst      clock, synchronous active-high reset
//   op_valid      valid EX-stage instruction; alu_op selects the operation
//   src_a, src_b  rs / rt operands
//   flush         abort in-flight op and ignore this cycle's op
//   stall         HI/LO-dependent op arrived while busy
//   hi, lo        architectural HI/LO
//   mf_data       MFHI/MFLO result
//   done          one-cycle pulse when a new mul/div result is visible
module muldiv_hilo import muldiv_hilo_pkg::*; #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [5:0]  alu_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_data,
   output logic        done
);
   localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
   md_state_t   state, state_n;
   logic [4:0]  cnt, cnt_n;
   logic        md_start, hilo_use, accept, sgn_op, is_mul;
   logic        neg_x, neg_r, b_zero, div_busy, mul_end, div_end;
   logic [31:0] abs_a, abs_b, mag_a, mag_b, quo, rem, q_fix, r_fix;
   logic [63:0] prod_u, prod;
   assign md_start = op_valid & (alu_op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU});
   assign hilo_use = op_valid & (alu_op inside {ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO});
   assign accept   = (state == MD_IDLE) & md_start & ~flush;
   assign stall    = (state != MD_IDLE) & (md_start | hilo_use) & ~flush;
   assign mf_data  = alu_op == ALU_MFHI ? hi : lo;
   assign sgn_op   = alu_op == ALU_MULT | alu_op == ALU_DIV;
   assign is_mul   = alu_op == ALU_MULT | alu_op == ALU_MULTU;
   assign abs_a    = mag32(src_a, sgn_op & src_a[31]);
   assign abs_b    = mag32(src_b, sgn_op & src_b[31]);
   assign prod_u   = {32'h0, mag_a} * {32'h0, mag_b};
   assign prod     = neg_x ? -prod_u : prod_u;
   // divide by zero keeps the all-ones quotient regardless of dividend sign
   assign q_fix    = b_zero ? '1 : mag32(quo, neg_x);
   assign r_fix    = mag32(rem, neg_r);
   assign mul_end  = state == MD_MUL & cnt == MUL_LAST;
   assign div_end  = state == MD_DIV & cnt == 5'd31 & div_busy;
   muldiv_hilo_div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept & ~is_mul),
      .abort     (flush),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .busy      (div_busy),
      .quotient  (quo),
      .remainder (rem)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   always_comb begin
      state_n = state;
      unique case (state)
         MD_IDLE: state_n = accept ? (is_mul ? MD_MUL : MD_DIV) : MD_IDLE;
         MD_MUL:  state_n = mul_end ? MD_IDLE : MD_MUL;
         MD_DIV:  state_n = div_end ? MD_FIX : MD_DIV;
         MD_FIX:  state_n = MD_IDLE;
      endcase
      if (flush) state_n = MD_IDLE;
      cnt_n = (state_n != state || state == MD_IDLE) ? 5'd0 : cnt + 5'd1;
   end
   always_ff @(posedge clk)
      if (rst) begin
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         neg_x  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         done <= ~flush & (mul_end | state == MD_FIX);
         if (accept) begin
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            neg_x  <= sgn_op & (src_a[31] ^ src_b[31]);
            neg_r  <= sgn_op & src_a[31];
            b_zero <= src_b == '0;
         end
         if (~flush) begin
            if (mul_end) {hi, lo} <= prod;
            else if (state == MD_FIX) begin
               hi <= r_fix;
               lo <= q_fix;
            end else if (state == MD_IDLE & op_valid & alu_op == ALU_MTHI) hi <= src_a;
            else if (state == MD_IDLE & op_valid & alu_op == ALU_MTLO) lo <= src_a;
         end
      end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed and random checks of muldiv_hilo against a cycle-level reference model
module tb_muldiv_hilo;
   import muldiv_hilo_pkg::*;
   localparam int MUL_LAT = 2;
   logic        clk = 0, rst = 1, op_valid = 0, flush = 0;
   logic [5:0]  alu_op = '0;
   logic [31:0] src_a = '0, src_b = '0;
   logic        stall, done;
   logic [31:0] hi, lo, mf_data;
   int checks = 0, errors = 0, cyc = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0, mt_data = 0;
   logic        p_valid = 0, mt_valid = 0, mt_hi = 0;
   int          end_cyc = 0, mt_cyc = 0;
   muldiv_hilo #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #5000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic logic is_md(input logic [5:0] op);
      return op == ALU_MULT || op == ALU_MULTU || op == ALU_DIV || op == ALU_DIVU;
   endfunction
   function automatic logic is_hilo(input logic [5:0] op);
      return op == ALU_MFHI || op == ALU_MFLO || op == ALU_MTHI || op == ALU_MTLO;
   endfunction
   function automatic int lat(input logic [5:0] op);
      return (op == ALU_MULT || op == ALU_MULTU) ? MUL_LAT : 33;
   endfunction
   function automatic logic [63:0] md_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int ia, ib;
      sa = $signed(a);
      sb = $signed(b);
      ia = a;
      ib = b;
      if (op == ALU_MULT) return sa * sb;
      if (op == ALU_MULTU) return {32'h0, a} * {32'h0, b};
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (op == ALU_DIVU) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      return {ia % ib, ia / ib};
   endfunction
   function automatic logic [31:0] rval();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return $urandom_range(0, 100);
         4: return -$urandom_range(1, 100);
         default: return $urandom;
      endcase
   endfunction
   task automatic tick();
      logic exp_stall, exp_done;
      @(negedge clk);
      exp_done = 0;
      if (p_valid && cyc >= end_cyc) begin
         m_hi = p_hi;
         m_lo = p_lo;
         p_valid = 0;
         exp_done = cyc == end_cyc;
      end
      if (mt_valid && cyc >= mt_cyc) begin
         if (mt_hi) m_hi = mt_data;
         else m_lo = mt_data;
         mt_valid = 0;
      end
      exp_stall = cyc < end_cyc && op_valid && (is_md(alu_op) || is_hilo(alu_op)) && !flush;
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      if (op_valid && (alu_op == ALU_MFHI || alu_op == ALU_MFLO) && !stall)
         check("mf_data", mf_data, alu_op == ALU_MFHI ? m_hi : m_lo);
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         tick();
         @(posedge clk); #1;
      end
   endtask
   task automatic do_reset();
      rst = 1;
      op_valid = 0;
      flush = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      m_hi = 0; m_lo = 0; p_valid = 0; mt_valid = 0; end_cyc = 0;
   endtask
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl,
                        output int n_stall, output logic [31:0] mf);
      op_valid = 1; alu_op = op; src_a = a; src_b = b; flush = fl; n_stall = 0;
      forever begin
         tick();
         if (!stall) break;
         n_stall++;
         if (n_stall > 40) begin
            check("stall_bound", {31'b0, stall}, 32'd0);
            break;
         end
         @(posedge clk); #1;
      end
      mf = mf_data;
      if (fl) begin
         if (cyc < end_cyc) begin
            p_valid = 0;
            end_cyc = cyc + 1;
         end
      end else if (is_md(op)) begin
         {p_hi, p_lo} = md_ref(op, a, b);
         p_valid = 1;
         end_cyc = cyc + 1 + lat(op);
      end else if (op == ALU_MTHI || op == ALU_MTLO) begin
         mt_valid = 1;
         mt_hi = op == ALU_MTHI;
         mt_data = a;
         mt_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      op_valid = 0;
      flush = 0;
   endtask
   initial begin
      int ns;
      logic [31:0] mf, hold_hi, hold_lo;
      logic [5:0] ops [9] = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO, 6'h20};
      do_reset();
      idle(2);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, ns, mf);
      idle(4);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);
      issue(ALU_MULT, -32'd3, 32'd5, 0, ns, mf);
      idle(3);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFF1);
      issue(ALU_DIV, -32'd7, 32'd2, 0, ns, mf);
      idle(1);
      issue(ALU_MFLO, 0, 0, 0, ns, mf);
      check("div_mflo_stall", ns, 32);
      check("div_mflo_data", mf, 32'hFFFFFFFD);
      check("div_hi", hi, 32'hFFFFFFFF);
      issue(ALU_DIVU, 32'd100, 32'd0, 0, ns, mf);
      idle(35);
      check("divu0_lo", lo, 32'hFFFFFFFF);
      check("divu0_hi", hi, 32'd100);
      issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, ns, mf);
      idle(35);
      check("divovf_lo", lo, 32'h80000000);
      check("divovf_hi", hi, 32'h0);
      issue(ALU_MTHI, 32'h1234, 0, 0, ns, mf);
      issue(ALU_MFHI, 0, 0, 0, ns, mf);
      check("mfhi_stall", ns, 0);
      check("mfhi_data", mf, 32'h1234);
      issue(ALU_DIV, 32'd200, 32'd7, 0, ns, mf);
      issue(ALU_MTLO, 32'hCAFE, 0, 0, ns, mf);
      check("mtlo_stall", ns, 33);
      idle(2);
      check("mtlo_lo", lo, 32'hCAFE);
      check("mtlo_hi", hi, 32'd4);
      hold_hi = hi;
      hold_lo = lo;
      issue(ALU_DIV, 32'd1000, 32'd3, 0, ns, mf);
      idle(10);
      issue(ALU_MULT, 32'd5, 32'd6, 1, ns, mf);
      issue(ALU_MFHI, 0, 0, 0, ns, mf);
      check("flush_stall", ns, 0);
      check("flush_hi", mf, hold_hi);
      idle(40);
      check("flush_lo", lo, hold_lo);
      issue(ALU_MULT, 32'd7, 32'd9, 0, ns, mf);
      do_reset();
      idle(4);
      check("rstmul_hi", hi, 32'h0);
      check("rstmul_lo", lo, 32'h0);
      for (int i = 0; i < 250; i++) begin
         issue(ops[$urandom_range(0, 8)], rval(), rval(), $urandom_range(0, 19) == 0, ns, mf);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 40));
      end
      idle(40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Execute-stage multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the instruction decoder. Consumes the decoded 6-bit alu_op for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO, plus the rs/rt operand values.
- Runs multiplies and divides as multi-cycle operations in the background.
- Raises a stall only when a later HI/LO-dependent instruction arrives before the result is committed.

Parameters:
- MUL_LAT, 2, multiply latency in cycles from accept to HI/LO write. Legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- op_valid  in  1  EX stage holds a valid, non-flushed instruction this cycle
- alu_op  in  6  decoded ALU operation, using the shared ALU op constants
- src_a  in  32  rs value (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  exception/ERET flush: abort the in-flight op, ignore this cycle's op
- stall  out  1  hold EX and upstream stages this cycle
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register
- mf_data  out  32  MFHI/MFLO result: hi or lo selected by alu_op, valid when stall=0
- done  out  1  one-cycle pulse, high in the first cycle HI/LO show a new mul/div result

Behaviour:
- Reset values: hi=0, lo=0, done=0, stall=0, state=IDLE, counter=0.
- Op classes:
  - md_start = op_valid & alu_op in {MULT, MULTU, DIV, DIVU}.
  - hilo_use = op_valid & alu_op in {MFHI, MFLO, MTHI, MTLO}.
- States: IDLE, MUL, DIV, FIX.
- stall = (state != IDLE) & (md_start | hilo_use) & ~flush. Combinational.
- Accept: in IDLE, md_start & ~flush. On that edge:
  - Latch operand magnitudes and sign flags (signed ops only).
  - Clear the counter.
  - Go to MUL or DIV.
- A md_start arriving while busy is stalled, not queued. It is accepted on the first cycle the state is IDLE.
- MUL:
  - 64-bit product of the latched operands: signed for MULT, unsigned for MULTU.
  - Counter increments each cycle.
  - At the edge where counter == MUL_LAT-1: {hi, lo} <= product, go to IDLE, done=1 next cycle.
  - HI/LO are therefore updated exactly MUL_LAT edges after accept.
- DIV: restoring radix-2 on 32-bit magnitudes, one quotient bit per cycle.
  - 32 iterations (counter 0..31), then FIX.
  - FIX (one cycle):
    - Quotient sign = sign_a ^ sign_b.
    - Remainder sign = sign_a.
    - Signs apply to DIV only.
    - lo <= quotient, hi <= remainder, go to IDLE, done=1 next cycle.
  - Total: HI/LO updated 33 edges after accept.
- Divide by zero (both DIV and DIVU): lo=32'hFFFFFFFF, hi=src_a. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: in IDLE, write src_a to hi/lo on the next edge. Only one HI/LO write per edge.
- MFHI/MFLO: mf_data = hi/lo combinationally. Stalled while busy, so it never returns a stale value.
- flush:
  - In any state, next state = IDLE and counter = 0. HI/LO are not written; no done pulse.
  - An op presented in the same cycle as flush is ignored, including MTHI/MTLO.
- rst mid-operation: identical to reset; HI/LO return to 0.
- done and an accept may coincide: done from the prior op, accept of the next in the same cycle.

Decomposition:
- Shared ALU package/header, owned alongside the decoder:
  - ALU op constants: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - md_state_t enum: IDLE, MUL, DIV, FIX.
- One natural sub-module: div_iter. It holds the 32-cycle unsigned restoring divider datapath (remainder/quotient shift registers plus counter), with start/busy/quotient/remainder ports.
- Multiply and the sign-fix logic stay in the top level.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_LAT=2 -> hi=0xFFFFFFFE, lo=0x00000001 exactly 2 edges after accept; done pulses once.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 33 edges. A MFLO issued 1 cycle after the DIV sees stall=1 for 32 cycles, then returns 0xFFFFFFFD.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 0x1234 in IDLE, then MFHI next cycle -> mf_data=0x1234, no stall. MTLO issued while DIV is busy -> stall until FIX completes, then lo=MTLO data, overriding the quotient.
- DIV started, flush at iteration 10 -> state IDLE next cycle, hi/lo unchanged, no done pulse. A MULT in the flush cycle is ignored. rst during MUL -> hi=lo=0.
